// File: rtl/waiting_ack_tracker_if.sv
// Flit types shared with the inter-device path, and the tracker's snoop/resend bundle.
// Tracker side uses the slave modport; the TX/RX environment uses master.
package types;
  typedef logic [3:0] node_id_t;
  typedef logic [7:0] flit_id_t;

  typedef struct packed {
    logic     is_ack;
    node_id_t src_id;
    node_id_t dst_id;
    flit_id_t flit_id;
  } header_t;

  typedef struct packed {
    header_t     header;
    logic [15:0] payload;
  } flit_t;
endpackage

interface waiting_ack_tracker_if #(
  parameter int unsigned NUM_ENTRIES = 8
);
  types::flit_t                       tx_flit;
  logic                               tx_valid;
  logic                               tx_ready;
  types::flit_t                       ack_flit;
  logic                               ack_valid;
  types::flit_t                       resend_flit;
  logic                               resend_valid;
  logic                               resend_ready;
  logic                               tracker_full;
  logic [$clog2(NUM_ENTRIES+1)-1:0]   outstanding;
  logic                               untracked_pulse;
  logic                               give_up_valid;
  types::node_id_t                    give_up_node_id;
  types::flit_id_t                    give_up_flit_id;

  modport slave (
    input  tx_flit, tx_valid, tx_ready, ack_flit, ack_valid, resend_ready,
    output resend_flit, resend_valid, tracker_full, outstanding, untracked_pulse,
           give_up_valid, give_up_node_id, give_up_flit_id
  );

  modport master (
    output tx_flit, tx_valid, tx_ready, ack_flit, ack_valid, resend_ready,
    input  resend_flit, resend_valid, tracker_full, outstanding, untracked_pulse,
           give_up_valid, give_up_node_id, give_up_flit_id
  );
endinterface

// File: rtl/waiting_ack_tracker.sv
// Multi-entry ack tracker: timeout resends through a round-robin held output register.
// Optional macro WAITING_ACK_BACKOFF_EN doubles the per-entry timeout on every resend.
module waiting_ack_tracker #(
  parameter int unsigned NUM_ENTRIES    = 8,
  parameter int unsigned MAX_RESEND_NUM = 3,
  parameter int unsigned BASE_TIMEOUT   = 100,
  parameter int unsigned TIMER_WIDTH    = 16
) (
  input  logic                  nocclk,
  input  logic                  rst,
  waiting_ack_tracker_if.slave  trk
);
  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);
  localparam int unsigned RN_W  = $clog2(MAX_RESEND_NUM + 2);
  localparam logic [TIMER_WIDTH-1:0] BASE_T = TIMER_WIDTH'(BASE_TIMEOUT);
  localparam logic [TIMER_WIDTH-1:0] ONE_T  = TIMER_WIDTH'(1);
  localparam logic [RN_W-1:0]        MAX_RN = RN_W'(MAX_RESEND_NUM);

  typedef enum logic [1:0] {E_FREE, E_WAITING, E_PENDING} entry_state_e;

  entry_state_e             state_q [NUM_ENTRIES];
  entry_state_e             state_d [NUM_ENTRIES];
  types::flit_t             flit_q  [NUM_ENTRIES];
  types::flit_t             flit_d  [NUM_ENTRIES];
  logic [RN_W-1:0]          rnum_q  [NUM_ENTRIES];
  logic [RN_W-1:0]          rnum_d  [NUM_ENTRIES];
  logic [TIMER_WIDTH-1:0]   timer_q [NUM_ENTRIES];
  logic [TIMER_WIDTH-1:0]   timer_d [NUM_ENTRIES];
  logic [TIMER_WIDTH-1:0]   tmo_q   [NUM_ENTRIES];
`ifdef WAITING_ACK_BACKOFF_EN
  logic [TIMER_WIDTH-1:0]   tmo_d   [NUM_ENTRIES];
`endif

  logic                     stage_valid_q, stage_valid_d;
  logic                     stage_live_q, stage_live_d;
  logic [IDX_W-1:0]         stage_idx_q, stage_idx_d;
  logic [IDX_W-1:0]         last_grant_q, last_grant_d;
  types::flit_t             stage_flit_q, stage_flit_d;
  logic                     gu_valid_q, gu_valid_d;
  types::node_id_t          gu_node_q, gu_node_d;
  types::flit_id_t          gu_id_q, gu_id_d;
  logic                     untracked_q, untracked_d;
  logic [CNT_W-1:0]         outstanding_q, outstanding_d;

  logic                     tx_hs, dup, full, free_found, stage_hs, can_load, sel_found;
  logic [IDX_W-1:0]         free_idx, sel_idx, cand;
  logic [NUM_ENTRIES-1:0]   ack_hit;
  logic                     unused_ack_bits;

  assign unused_ack_bits = ^{trk.ack_flit.payload, trk.ack_flit.header.dst_id};

  always_comb begin
    state_d       = state_q;
    flit_d        = flit_q;
    rnum_d        = rnum_q;
    timer_d       = timer_q;
`ifdef WAITING_ACK_BACKOFF_EN
    tmo_d         = tmo_q;
`endif
    stage_valid_d = stage_valid_q;
    stage_live_d  = stage_live_q;
    stage_idx_d   = stage_idx_q;
    last_grant_d  = last_grant_q;
    stage_flit_d  = stage_flit_q;
    gu_valid_d    = 1'b0;
    gu_node_d     = gu_node_q;
    gu_id_d       = gu_id_q;
    untracked_d   = 1'b0;
    outstanding_d = '0;
    tx_hs         = trk.tx_valid && trk.tx_ready && !trk.tx_flit.header.is_ack;
    dup           = 1'b0;
    full          = 1'b1;
    free_found    = 1'b0;
    free_idx      = '0;
    ack_hit       = '0;
    sel_found     = 1'b0;
    sel_idx       = '0;
    cand          = '0;

    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (state_q[i] == E_FREE) begin
        full = 1'b0;
        if (!free_found) begin
          free_found = 1'b1;
          free_idx   = IDX_W'(i);
        end
      end else begin
        if (flit_q[i].header.dst_id == trk.tx_flit.header.dst_id &&
            flit_q[i].header.flit_id == trk.tx_flit.header.flit_id)
          dup = 1'b1;
        if (trk.ack_valid && trk.ack_flit.header.is_ack &&
            flit_q[i].header.dst_id == trk.ack_flit.header.src_id &&
            flit_q[i].header.flit_id == trk.ack_flit.header.flit_id)
          ack_hit[i] = 1'b1;
      end
    end

    // Only one give-up per cycle: later candidates keep counting and retry next cycle (>= compare).
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (state_q[i] == E_WAITING && !ack_hit[i]) begin
        if (timer_q[i] >= tmo_q[i] - ONE_T) begin
          if (rnum_q[i] < MAX_RN) begin
            state_d[i] = E_PENDING;
          end else if (!gu_valid_d) begin
            state_d[i] = E_FREE;
            gu_valid_d = 1'b1;
            gu_node_d  = flit_q[i].header.dst_id;
            gu_id_d    = flit_q[i].header.flit_id;
          end else begin
            timer_d[i] = timer_q[i] + ONE_T;
          end
        end else begin
          timer_d[i] = timer_q[i] + ONE_T;
        end
      end
    end

    stage_hs = stage_valid_q && trk.resend_ready;
    if (stage_hs && stage_live_q && !ack_hit[stage_idx_q]) begin
      state_d[stage_idx_q] = E_WAITING;
      rnum_d[stage_idx_q]  = rnum_q[stage_idx_q] + RN_W'(1);
      timer_d[stage_idx_q] = '0;
`ifdef WAITING_ACK_BACKOFF_EN
      tmo_d[stage_idx_q]   = tmo_q[stage_idx_q][TIMER_WIDTH-1] ? '1
                             : {tmo_q[stage_idx_q][TIMER_WIDTH-2:0], 1'b0};
`endif
    end
    if (stage_valid_q && ack_hit[stage_idx_q])
      stage_live_d = 1'b0;

    can_load = !stage_valid_q || stage_hs;
    for (int unsigned k = 1; k <= NUM_ENTRIES; k++) begin
      cand = last_grant_q + IDX_W'(k);
      if (!sel_found && state_q[cand] == E_PENDING && !ack_hit[cand] &&
          !(stage_valid_q && stage_live_q && cand == stage_idx_q)) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
    if (can_load) begin
      stage_valid_d = sel_found;
      if (sel_found) begin
        stage_idx_d  = sel_idx;
        stage_flit_d = flit_q[sel_idx];
        stage_live_d = 1'b1;
        last_grant_d = sel_idx;
      end
    end

    if (tx_hs && !dup) begin
      if (free_found) begin
        state_d[free_idx] = E_WAITING;
        flit_d[free_idx]  = trk.tx_flit;
        rnum_d[free_idx]  = '0;
        timer_d[free_idx] = '0;
`ifdef WAITING_ACK_BACKOFF_EN
        tmo_d[free_idx]   = BASE_T;
`endif
      end else begin
        untracked_d = 1'b1;
      end
    end

    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (ack_hit[i])
        state_d[i] = E_FREE;
      if (state_d[i] != E_FREE)
        outstanding_d = outstanding_d + CNT_W'(1);
    end
  end

  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= E_FREE;
        flit_q[i]  <= '0;
        rnum_q[i]  <= '0;
        timer_q[i] <= '0;
      end
      stage_valid_q <= 1'b0;
      stage_live_q  <= 1'b0;
      stage_idx_q   <= '0;
      last_grant_q  <= IDX_W'(NUM_ENTRIES - 1);
      stage_flit_q  <= '0;
      gu_valid_q    <= 1'b0;
      gu_node_q     <= '0;
      gu_id_q       <= '0;
      untracked_q   <= 1'b0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      flit_q        <= flit_d;
      rnum_q        <= rnum_d;
      timer_q       <= timer_d;
      stage_valid_q <= stage_valid_d;
      stage_live_q  <= stage_live_d;
      stage_idx_q   <= stage_idx_d;
      last_grant_q  <= last_grant_d;
      stage_flit_q  <= stage_flit_d;
      gu_valid_q    <= gu_valid_d;
      gu_node_q     <= gu_node_d;
      gu_id_q       <= gu_id_d;
      untracked_q   <= untracked_d;
      outstanding_q <= outstanding_d;
    end
  end

`ifdef WAITING_ACK_BACKOFF_EN
  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++)
        tmo_q[i] <= BASE_T;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < NUM_ENTRIES; i++)
      tmo_q[i] = BASE_T;
  end
`endif

  assign trk.resend_flit     = stage_flit_q;
  assign trk.resend_valid    = stage_valid_q;
  assign trk.tracker_full    = full;
  assign trk.outstanding     = outstanding_q;
  assign trk.untracked_pulse = untracked_q;
  assign trk.give_up_valid   = gu_valid_q;
  assign trk.give_up_node_id = gu_node_q;
  assign trk.give_up_flit_id = gu_id_q;
endmodule
